// File: rtl/dmem_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_scan_ctrl
// Description : Data-memory scan controller. A fill job writes an arithmetic
//               sequence to a window of memory. A dump job reads a window out
//               through a valid/ready stream. Address windows wrap modulo DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_scan_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  MODE,
    input  logic [AW-1:0]         BASE,
    input  logic [AW:0]           COUNT,
    input  logic [DATA_WIDTH-1:0] FILL_DATA,
    input  logic [DATA_WIDTH-1:0] FILL_STEP,
    input  logic                  ABORT,
    output logic                  MEM_WE,
    output logic [DATA_WIDTH-1:0] MEM_A,
    output logic [DATA_WIDTH-1:0] MEM_WD,
    input  logic [DATA_WIDTH-1:0] MEM_RD,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic [AW-1:0]         OUT_ADDR,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_RDADDR = 3'd2,
        S_RDWAIT = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    state_t                state_q;
    logic [AW-1:0]         addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] step_q;
    logic [AW:0]           rem_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [AW-1:0]         out_addr_q;
    logic [AW-1:0]         last_a_q;
    logic                  err_q;

    logic [AW-1:0]         mem_a_d;
    logic [AW-1:0]         addr_inc_d;
    logic                  count_ok_d;
    logic                  last_word_d;

    // Address/limit decode and output drive; MEM_A holds its last value outside active-address states
    always_comb begin
        mem_a_d = last_a_q;
        if (state_q == S_FILL || state_q == S_RDADDR) begin
            mem_a_d = addr_q;
        end
        addr_inc_d  = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
        count_ok_d  = (COUNT != '0) && (COUNT <= (AW+1)'(DEPTH));
        last_word_d = (rem_q == (AW+1)'(1));

        // Write strobe is gated by ABORT so an aborted cycle never writes
        MEM_WE    = (state_q == S_FILL) && !ABORT;
        MEM_WD    = (state_q == S_FILL) ? data_q : '0;
        MEM_A     = {{(DATA_WIDTH-AW){1'b0}}, mem_a_d};
        OUT_VALID = (state_q == S_RDWAIT);
        OUT_DATA  = out_data_q;
        OUT_ADDR  = out_addr_q;
        BUSY      = (state_q != S_IDLE);
        DONE      = (state_q == S_FIN);
        ERR       = err_q;
    end

    // Job FSM: accepts/rejects starts, sequences fill writes and dump handshakes
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            step_q     <= '0;
            rem_q      <= '0;
            out_data_q <= '0;
            out_addr_q <= '0;
            last_a_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q    <= 1'b0;
            last_a_q <= mem_a_d;
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        if (count_ok_d) begin
                            addr_q  <= BASE;
                            data_q  <= FILL_DATA;
                            step_q  <= FILL_STEP;
                            rem_q   <= COUNT;
                            state_q <= MODE ? S_FILL : S_RDADDR;
                        end else begin
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (ABORT) begin
                        state_q <= S_IDLE;
                    end else begin
                        addr_q <= addr_inc_d;
                        data_q <= data_q + step_q;
                        rem_q  <= rem_q - 1'b1;
                        if (last_word_d) begin
                            state_q <= S_FIN;
                        end
                    end
                end
                S_RDADDR: begin
                    if (ABORT) begin
                        state_q <= S_IDLE;
                    end else begin
                        out_data_q <= MEM_RD;
                        out_addr_q <= addr_q;
                        state_q    <= S_RDWAIT;
                    end
                end
                S_RDWAIT: begin
                    // ABORT wins over a simultaneous OUT_READY: the word is dropped
                    if (ABORT) begin
                        state_q <= S_IDLE;
                    end else if (OUT_READY) begin
                        if (last_word_d) begin
                            state_q <= S_FIN;
                        end else begin
                            addr_q  <= addr_inc_d;
                            rem_q   <= rem_q - 1'b1;
                            state_q <= S_RDADDR;
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
